// File: rtl/my_slv_rx_pkg.sv
// Shared types and constants for the my_slv_rx link receiver.
// Optional statistics are enabled by defining MY_SLV_RX_STATS_EN.
package my_slv_rx_pkg;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;

    typedef logic [DATA_W-1:0] data_t;

    localparam logic [CNT_W-1:0] DROP_SAT = {CNT_W{1'b1}};

endpackage

// File: rtl/my_slv_rx_if.sv
// Link-side word stream plus the downstream valid/ready port of my_slv_rx.
interface my_slv_rx_if;
    import my_slv_rx_pkg::*;

    logic  in_vld;
    data_t in_data;
    logic  out_vld;
    data_t out_data;
    logic  out_rdy;

    modport master (
        output in_vld,
        output in_data,
        output out_rdy,
        input  out_vld,
        input  out_data
    );

    modport slave (
        input  in_vld,
        input  in_data,
        input  out_rdy,
        output out_vld,
        output out_data
    );

endinterface

// File: rtl/my_slv_rx_fifo.sv
// First-word-fall-through FIFO: the head word sits in a register so the
// output never shows X and holds its last value once the FIFO drains.
module my_slv_rx_fifo
    import my_slv_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  data_t                      wr_data,
    output data_t                      rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [$clog2(DEPTH+1)-1:0] level_nxt,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    data_t            mem [DEPTH];

    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        level_nxt  = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The next head either comes from storage or, when it is the word being
    // written this very cycle, straight from wr_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            if (level_nxt != '0) begin
                rd_data <= (push && (rd_ptr_nxt == wr_ptr)) ? wr_data : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/my_slv_rx.sv
// Receive endpoint of the my_mst link: buffers words, tracks drops on overflow.
// Define MY_SLV_RX_STATS_EN to add the rx_cnt and max_level statistics ports.
module my_slv_rx
    import my_slv_rx_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    my_slv_rx_if.slave                 bus,
    input  logic                       clr_ovf,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
`ifdef MY_SLV_RX_STATS_EN
    ,
    output logic [31:0]                rx_cnt,
    output logic [$clog2(DEPTH+1)-1:0] max_level
`endif
);

    localparam int LVL_W = $clog2(DEPTH+1);

    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level_nxt;

    // No backpressure on the link: a word arriving while full survives only
    // if the downstream frees a slot in the same cycle.
    assign bus.out_vld = !empty;
    assign pop         = bus.out_vld && bus.out_rdy;
    assign push        = bus.in_vld && (!full || pop);
    assign drop        = bus.in_vld && full && !pop;

    my_slv_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wr_data   (bus.in_data),
        .rd_data   (bus.out_data),
        .level     (level),
        .level_nxt (level_nxt),
        .full      (full),
        .empty     (empty)
    );

    // A clear in the same cycle as a drop wipes the history first, so that
    // drop is still recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            almost_full <= (level_nxt >= LVL_W'(AF_LEVEL));
            if (clr_ovf) begin
                overflow <= drop;
                drop_cnt <= drop ? CNT_W'(1) : '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != DROP_SAT) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef MY_SLV_RX_STATS_EN
    // After a clear the high-water mark restarts from the current occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt    <= '0;
            max_level <= '0;
        end else begin
            if (push) begin
                rx_cnt <= rx_cnt + 32'd1;
            end
            if (clr_ovf || (level_nxt > max_level)) begin
                max_level <= level_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_my_slv_rx.sv
// Scoreboard testbench for my_slv_rx (DEPTH=16, AF_LEVEL=12).
module tb_my_slv_rx;
    import my_slv_rx_pkg::*;

    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int LVL_W    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr_ovf = 1'b0;
    logic [LVL_W-1:0] level;
    logic             almost_full;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
`ifdef MY_SLV_RX_STATS_EN
    logic [31:0]      rx_cnt;
    logic [LVL_W-1:0] max_level;
`endif

    my_slv_rx_if bus ();

    my_slv_rx #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clr_ovf     (clr_ovf),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
`ifdef MY_SLV_RX_STATS_EN
        ,
        .rx_cnt      (rx_cnt),
        .max_level   (max_level)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    data_t       sb[$];
    int          m_level  = 0;
    logic        m_ovf    = 1'b0;
    logic [15:0] m_drop   = '0;
    int          m_rx     = 0;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic model_reset();
        m_level = 0;
        m_ovf   = 1'b0;
        m_drop  = '0;
        m_rx    = 0;
        sb.delete();
    endtask

    // Drives one cycle and advances the reference model; callers pop sb
    // themselves when they expect a pop to happen on this edge.
    task automatic drive(input logic vld, input data_t data, input logic rdy, input logic clr);
        logic pm, psh, drp;
        bus.in_vld  = vld;
        bus.in_data = data;
        bus.out_rdy = rdy;
        clr_ovf     = clr;
        pm  = (m_level != 0) && rdy;
        psh = vld && ((m_level < DEPTH) || pm);
        drp = vld && (m_level == DEPTH) && !pm;
        if (psh) sb.push_back(data);
        if (psh && !pm) m_level++;
        else if (pm && !psh) m_level--;
        if (clr) begin
            m_ovf  = drp;
            m_drop = drp ? 16'd1 : 16'd0;
        end else if (drp) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop++;
        end
        if (psh) m_rx++;
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
        clr_ovf    = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        clr_ovf     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_vld !== 1'b0 || bus.out_data !== 12'h000 || level !== '0) begin
            failures++;
            $display("[TB] FAIL reset_out vld=%b data=%h level=%0d required 0/000/0", bus.out_vld, bus.out_data, level);
        end
        checks++;
        if (almost_full !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_flags af=%b ovf=%b drop=%0d required 0/0/0", almost_full, overflow, drop_cnt);
        end
    endtask

    task automatic test_single_word();
        drive(1'b1, 12'hA5C, 1'b1, 1'b0);
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 12'hA5C || level !== LVL_W'(1)) begin
            failures++;
            $display("[TB] FAIL single_word vld=%b data=%h level=%0d required 1/a5c/1", bus.out_vld, bus.out_data, level);
        end
        void'(sb.pop_front());
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        checks++;
        if (bus.out_vld !== 1'b0 || level !== '0 || bus.out_data !== 12'hA5C) begin
            failures++;
            $display("[TB] FAIL single_drain vld=%b level=%0d data=%h required 0/0/a5c", bus.out_vld, level, bus.out_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, data_t'(i), 1'b0, 1'b0);
            checks++;
            if (level !== LVL_W'(m_level) || almost_full !== (m_level >= AF_LEVEL)) begin
                failures++;
                $display("[TB] FAIL fill_level i=%0d level=%0d af=%b required %0d/%b", i, level, almost_full, m_level, m_level >= AF_LEVEL);
            end
        end
        checks++;
        if (level !== LVL_W'(16) || overflow !== 1'b0 || bus.out_data !== 12'h001) begin
            failures++;
            $display("[TB] FAIL fill_full level=%0d ovf=%b head=%h required 16/0/001", level, overflow, bus.out_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) drive(1'b1, 12'hE00 + data_t'(i), 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd3) begin
            failures++;
            $display("[TB] FAIL overflow ovf=%b drop=%0d required 1/3", overflow, drop_cnt);
        end
        checks++;
        if (level !== LVL_W'(16) || bus.out_data !== 12'h001 || sb.size() != 16) begin
            failures++;
            $display("[TB] FAIL overflow_keep level=%0d head=%h sb=%0d required 16/001/16", level, bus.out_data, sb.size());
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 12'hBAD, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL clear_with_drop ovf=%b drop=%0d required 1/1", overflow, drop_cnt);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL clear_alone ovf=%b drop=%0d required 0/0", overflow, drop_cnt);
        end
    endtask

    task automatic test_full_pop();
        data_t last;
        checks++;
        if (bus.out_data !== sb[0]) begin
            failures++;
            $display("[TB] FAIL fullpop_head got=%h required %h", bus.out_data, sb[0]);
        end
        void'(sb.pop_front());
        drive(1'b1, 12'h7FF, 1'b1, 1'b0);
        checks++;
        if (level !== LVL_W'(16) || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fullpop_level level=%0d drop=%0d ovf=%b required 16/0/0", level, drop_cnt, overflow);
        end
        last = '0;
        for (int n = 0; n < 2 * DEPTH && sb.size() != 0; n++) begin
            checks++;
            if (bus.out_vld !== 1'b1 || bus.out_data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL drain_order vld=%b got=%h required 1/%h", bus.out_vld, bus.out_data, sb[0]);
            end
            last = sb.pop_front();
            drive(1'b0, 12'h000, 1'b1, 1'b0);
        end
        checks++;
        if (last !== 12'h7FF || bus.out_vld !== 1'b0 || level !== '0) begin
            failures++;
            $display("[TB] FAIL drain_last last=%h vld=%b level=%0d required 7ff/0/0", last, bus.out_vld, level);
        end
    endtask

    // Random traffic long enough to wrap the pointers several times.
    task automatic test_back_to_back();
        logic  v, r;
        data_t d;
        for (int n = 0; n < 200; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0) || (n >= 150);
            d = data_t'($urandom);
            checks++;
            if (bus.out_vld !== (sb.size() != 0) || level !== LVL_W'(m_level)
                || overflow !== m_ovf || drop_cnt !== m_drop) begin
                failures++;
                $display("[TB] FAIL b2b_state n=%0d vld=%b level=%0d ovf=%b drop=%0d required %b/%0d/%b/%0d",
                         n, bus.out_vld, level, overflow, drop_cnt, sb.size() != 0, m_level, m_ovf, m_drop);
            end
            if (r && sb.size() != 0) begin
                checks++;
                if (bus.out_data !== sb[0]) begin
                    failures++;
                    $display("[TB] FAIL b2b_data n=%0d got=%h required %h", n, bus.out_data, sb[0]);
                end
                void'(sb.pop_front());
            end
            drive(v, d, r, 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5 - m_level && m_level < 5; i++) drive(1'b1, 12'h300 + data_t'(i), 1'b0, 1'b0);
        checks++;
        if (level !== LVL_W'(m_level)) begin
            failures++;
            $display("[TB] FAIL midrst_pre level=%0d required %0d", level, m_level);
        end
        rst         = 1'b1;
        bus.in_vld  = 1'b1;
        bus.in_data = 12'h123;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.in_vld = 1'b0;
        model_reset();
        checks++;
        if (level !== '0 || bus.out_vld !== 1'b0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst level=%0d vld=%b drop=%0d ovf=%b required 0/0/0/0", level, bus.out_vld, drop_cnt, overflow);
        end
`ifdef MY_SLV_RX_STATS_EN
        checks++;
        if (rx_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL rx_cnt_reset got=%0d required 0", rx_cnt);
        end
        drive(1'b1, 12'h055, 1'b0, 1'b0);
        checks++;
        if (rx_cnt !== 32'd1 || max_level !== LVL_W'(1)) begin
            failures++;
            $display("[TB] FAIL rx_cnt_inc cnt=%0d max=%0d required 1/1", rx_cnt, max_level);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_overflow();
        test_clear();
        test_full_pop();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
